operand_scoreboard: RTL and testbench

//  Sequences issue from the ID stage so that the source operands fed to operand generation are valid.

---
 rtl/operand_scoreboard_pkg.sv | 18 +
 rtl/operand_scoreboard_entry.sv | 41 ++++
 rtl/operand_scoreboard.sv | 103 ++++++++++
 tb/tb_operand_scoreboard.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/operand_scoreboard_pkg.sv
// Shared scoreboard definitions: default dimensions, FSM encodings and the
// canonical producer latencies used by the decoder when filling wr_lat.
package operand_scoreboard_pkg;

  localparam int SB_REG_NUM = 32;
  localparam int SB_ADDR_W  = 5;
  localparam int SB_CNT_W   = 3;
  localparam int SB_PERF_W  = 16;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_STALL = 1'b1
  } sb_state_e;

  localparam logic [SB_CNT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [SB_CNT_W-1:0] LAT_LOAD = 3'd1;

endpackage

// File: rtl/operand_scoreboard_entry.sv
// One register's countdown: cycles remaining until its pending result can be
// forwarded. A load from a newly issued writer overrides any decrement.
module sb_entry
  import operand_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // next countdown value
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = lat_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // countdown register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/operand_scoreboard.sv
// ID-stage operand scoreboard: stalls issue while a source register still has
// an unforwardable result pending, and counts stalled cycles.
module operand_scoreboard
  import operand_scoreboard_pkg::*;
#(
  parameter int REG_NUM = SB_REG_NUM,
  parameter int ADDR_W  = SB_ADDR_W,
  parameter int CNT_W   = SB_CNT_W,
  parameter int PERF_W  = SB_PERF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              rs_read_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              rt_read_en,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_lat,
  output logic              stall_req,
  output logic [1:0]        stall_src,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [CNT_W-1:0]  pending_s [REG_NUM];
  logic              rs_hit_s;
  logic              rt_hit_s;
  logic              stall_s;
  logic              issue_s;
  sb_state_e         state_d;
  sb_state_e         state_q;
  logic [PERF_W-1:0] stall_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q;

  assign pending_s[0] = LAT_ALU;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk    (clk),
      .rst    (rst),
      .load_i (issue_s & wr_en & (wr_addr == ADDR_W'(r))),
      .lat_i  (wr_lat),
      .cnt_o  (pending_s[r])
    );
  end

  // hazard compare; addresses are only looked at when the read is real
  always_comb begin
    rs_hit_s = 1'b0;
    rt_hit_s = 1'b0;
    if (id_valid && rs_read_en && (rs_addr != {ADDR_W{1'b0}})) begin
      rs_hit_s = (pending_s[rs_addr] != LAT_ALU);
    end else begin
      rs_hit_s = 1'b0;
    end
    if (id_valid && rt_read_en && (rt_addr != {ADDR_W{1'b0}})) begin
      rt_hit_s = (pending_s[rt_addr] != LAT_ALU);
    end else begin
      rt_hit_s = 1'b0;
    end
  end

  assign stall_s = id_valid & ~flush & (rs_hit_s | rt_hit_s);
  assign issue_s = id_valid & ~stall_s & ~flush;

  // stall FSM next state and saturating perf counter
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      state_d = SB_RUN;
    end else begin
      case (state_q)
        SB_RUN:   state_d = stall_s ? SB_STALL : SB_RUN;
        SB_STALL: state_d = stall_s ? SB_STALL : SB_RUN;
        default:  state_d = SB_RUN;
      endcase
    end
    if (stall_s && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SB_RUN;
      stall_cnt_q <= {PERF_W{1'b0}};
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_req = stall_s;
  assign stall_src = stall_s ? {rt_hit_s, rs_hit_s} : 2'b00;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_scoreboard.sv
// Randomized + directed bench for operand_scoreboard; the reference model tracks
// the absolute cycle at which each register's result becomes forwardable.
module tb_operand_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        rs_read_en = 1'b0;
  logic [4:0]  rs_addr = 5'd0;
  logic        rt_read_en = 1'b0;
  logic [4:0]  rt_addr = 5'd0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [2:0]  wr_lat = 3'd0;
  logic        stall_req;
  logic [1:0]  stall_src;
  logic [15:0] stall_cnt;

  operand_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .id_valid   (id_valid),
    .rs_read_en (rs_read_en),
    .rs_addr    (rs_addr),
    .rt_read_en (rt_read_en),
    .rt_addr    (rt_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_lat     (wr_lat),
    .stall_req  (stall_req),
    .stall_src  (stall_src),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [1:0]  src;
    logic [15:0] cnt;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_on = 1'b0;

  // Reference model: absolute cycle when each register becomes forwardable
  longint ready_at [32];
  longint cyc = 0;
  int     cnt_m = 0;
  bit     last_stall = 1'b0;

  // Monitor: compares every presented output against the queued expectation
  always @(negedge clk) begin
    if (mon_on) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL queue_empty: no expectation available at time %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (stall_req !== e.stall) begin
          n_fail++;
          $display("FAIL stall_req cyc=%0d: got %b expected %b", cyc, stall_req, e.stall);
        end
        n_checks++;
        if (stall_src !== e.src) begin
          n_fail++;
          $display("FAIL stall_src cyc=%0d: got %b expected %b", cyc, stall_src, e.src);
        end
        n_checks++;
        if (stall_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL stall_cnt cyc=%0d: got %0d expected %0d", cyc, stall_cnt, e.cnt);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
    cnt_m = 0;
  endtask

  // One clock: predict outputs for the current inputs, then advance the model
  task automatic tick();
    bit   hrs, hrt, stl, iss;
    exp_t e;
    hrs = id_valid && rs_read_en && (rs_addr != 5'd0) && (cyc < ready_at[rs_addr]);
    hrt = id_valid && rt_read_en && (rt_addr != 5'd0) && (cyc < ready_at[rt_addr]);
    stl = id_valid && !flush && (hrs || hrt);
    iss = id_valid && !stl && !flush;
    e.stall = stl;
    e.src   = stl ? {hrt, hrs} : 2'b00;
    e.cnt   = 16'(cnt_m);
    last_stall = stl;
    exp_q.push_back(e);
    mon_on = 1'b1;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (stl && cnt_m < 65535) cnt_m++;
      if (iss && wr_en && wr_addr != 5'd0) ready_at[wr_addr] = cyc + 1 + longint'(wr_lat);
    end
    cyc++;
    #1;
  endtask

  task automatic instr(input bit v, input bit rse, input int rs, input bit rte, input int rt,
                       input bit we, input int wa, input int lat);
    id_valid = v; rs_read_en = rse; rs_addr = 5'(rs); rt_read_en = rte; rt_addr = 5'(rt);
    wr_en = we; wr_addr = 5'(wa); wr_lat = 3'(lat);
  endtask

  task automatic idle();
    instr(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    tick();
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // 1: clean state, reading r5 cannot stall
    instr(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0, 0); tick();
    idle();

    // 2: load-use, one bubble
    instr(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 8, 1); tick();
    instr(1'b1, 1'b1, 8, 1'b1, 0, 1'b1, 12, 0); tick(); tick();
    idle();

    // 3: three-cycle producer, consumer on rt
    instr(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 9, 3); tick();
    instr(1'b1, 1'b0, 0, 1'b1, 9, 1'b0, 0, 0); repeat (4) tick();
    idle();

    // 4: WAW, younger ALU write clears the entry
    instr(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 10, 3); tick();
    instr(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 10, 0); tick();
    instr(1'b1, 1'b1, 10, 1'b0, 0, 1'b0, 0, 0); tick();
    idle();

    // 5: r0 never pending; flush mid-stall keeps older countdown running
    instr(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 3); tick();
    instr(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0, 0); tick();
    instr(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 11, 5); tick();
    instr(1'b1, 1'b1, 11, 1'b0, 0, 1'b0, 0, 0); tick();
    flush = 1'b1; tick();
    flush = 1'b0; repeat (5) tick();
    idle();

    // random traffic over a narrow register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      instr(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 199) != 0);
      tick();
    end
    flush = 1'b0; rst = 1'b1;
    idle();

    // 6: self-dependent long producer keeps stalling 7 of every 8 cycles
    instr(1'b1, 1'b1, 1, 1'b0, 0, 1'b1, 1, 7);
    repeat (74920) tick();
    for (int k = 0; k < 16 && !last_stall; k++) tick();
    rst = 1'b0; tick();
    rst = 1'b1; tick(); tick();
    idle();

    mon_on = 1'b0;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
